// File: rtl/div8_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and counter sizing.
package div8_seq_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // The counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div8_seq_div_step.sv
// One restoring-division step: shift {P,Q} left, trial-subtract D, keep the difference on no-borrow.
module div8_seq_div_step
    import div8_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] q_next,
    output logic             take
);

    logic             msb;
    logic [WIDTH-1:0] p_sh;
    logic [WIDTH:0]   sum;

    assign msb  = p[WIDTH-1];
    assign p_sh = {p[WIDTH-2:0], q[WIDTH-1]};

    // P' + ~D + 1: carry-out set means P' >= D.
    assign sum  = {1'b0, p_sh} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};

    // A set msb means the shifted remainder exceeds any WIDTH-bit divisor.
    assign take   = msb | sum[WIDTH];
    assign p_next = take ? sum[WIDTH-1:0] : p_sh;
    assign q_next = {q[WIDTH-2:0], take};

endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider with start/busy/done handshake; one quotient bit per clock.
module div8_seq
    import div8_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] p_step, q_step;
    logic             take;
    logic             unused_take;

    div8_seq_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .p      (p_q),
        .q      (q_q),
        .d      (d_q),
        .p_next (p_step),
        .q_next (q_step),
        .take   (take)
    );

    // The quotient bit already lands in q_step; take is only needed standalone by other users.
    assign unused_take = take;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (b != '0) begin
                        state_d = StRun;
                        p_d     = '0;
                        q_d     = a;
                        d_d     = b;
                        cnt_d   = CntW'(WIDTH);
                    end else begin
                        // Divide-by-zero completes immediately without entering RUN.
                        quo_d  = '1;
                        rem_d  = a;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                p_d   = p_step;
                q_d   = q_step;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    quo_d   = q_step;
                    rem_d   = p_step;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Scoreboard bench for div8_seq: a driver queues expected results, a monitor checks each done pulse.
module tb_div8_seq;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, dz;
    logic [W-1:0] quo, rem;

    div8_seq #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quo   (quo),
        .rem   (rem),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int passed   = 0;
    int free_cyc = 0;  // first negedge cycle at which the model is idle again
    int busy_lo  = 0;  // first negedge cycle at which the model is busy
    logic [W-1:0] last_quo, last_rem;
    logic         last_dz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called on a negedge; the model decides whether the DUT should accept the request.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        if (cyc >= free_cyc) begin
            e.dz  = (ib == 0);
            e.quo = e.dz ? {W{1'b1}} : ia / ib;
            e.rem = e.dz ? ia : ia % ib;
            e.cyc = cyc + 1 + (e.dz ? 0 : W);
            sb.push_back(e);
            busy_lo  = cyc + 1;
            free_cyc = e.cyc;
        end
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && cyc < free_cyc; i++) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            automatic logic mbusy = (cyc >= busy_lo) && (cyc < free_cyc);
            exp_t e;
            chk("busy", busy, mbusy);
            if (mbusy) begin
                chk("quo_hold", quo, last_quo);
                chk("rem_hold", rem, last_rem);
                chk("dz_hold", dz, last_dz);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quo", quo, e.quo);
                    chk("rem", rem, e.rem);
                    chk("dz", dz, e.dz);
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                checks++;
                $display("FAIL missing_done: got done=0, expected done at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
            last_quo = quo;
            last_rem = rem;
            last_dz  = dz;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;

        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quo", quo, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(200, 7);
        drain();
        issue(255, 1);
        drain();
        issue(5, 9);
        drain();
        issue(255, 255);
        drain();
        issue(13, 0);
        drain();

        // Second start while busy must be ignored.
        issue(100, 3);
        repeat (2) @(negedge clk);
        issue(50, 5);
        drain();

        // Reset mid-operation aborts without a done pulse.
        issue(200, 7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quo", quo, 0);
        chk("abort_rem", rem, 0);
        chk("abort_dz", dz, 0);
        sb.delete();
        free_cyc = 0;
        busy_lo  = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(9, 3);
        drain();

        // Back-to-back: second start lands in the first done cycle.
        issue(17, 4);
        wait_idle();
        issue(60, 6);
        drain();

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                issue(ra, rb);
            end else begin
                wait_idle();
                if ($urandom_range(0, 1) == 1) @(negedge clk);
                issue(ra, rb);
            end
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
